axi_lite_clint: RTL and testbench
=================================

AXI_LITE_CLINT -- requirements
Module: axi_lite_clint

Interface
REQ-001 SHALL have parameter DIV, default 16: number of i_clk cycles per mtime tick when CLINT_PRESCALER_EN is defined; legal range 2..65535.
REQ-002 SHALL have ports i_clk (input, 1): the single clock; all logic is in this domain.
REQ-003 SHALL have port i_rst (input, 1): asynchronous, active-high reset.
REQ-004 SHALL have AW channel ports: awaddr (input, 32), awvalid (input, 1), awready (output, 1).
REQ-005 SHALL have W channel ports: wdata (input, 32), wstrb (input, 4), wvalid (input, 1), wready (output, 1).
REQ-006 SHALL have B channel ports: bresp (output, 2), bvalid (output, 1), bready (input, 1).
REQ-007 SHALL have AR channel ports: araddr (input, 32), arvalid (input, 1), arready (output, 1).
REQ-008 SHALL have R channel ports: rdata (output, 32), rresp (output, 2), rvalid (output, 1), rready (input, 1).
REQ-009 SHALL have port o_mtip (output, 1): machine timer interrupt pending, registered.

Function
REQ-010 SHALL act as an AXI-lite responder that sits behind the same AXI-lite fabric as the SRAM, with a register map decoded on addr[3:2]: 0 MTIME_LO, 1 MTIME_HI, 2 MTIMECMP_LO, 3 MTIMECMP_HI.
REQ-011 SHALL ignore addr[1:0] and addr[31:12]; a nonzero addr[11:4] SHALL be treated as a decode error.
REQ-012 SHALL implement the read FSM with two states: R_IDLE (arready=1, rvalid=0) and R_DATA (arready=0, rvalid=1).
REQ-013 SHALL move from R_IDLE to R_DATA on arvalid, registering rdata and rresp in that cycle, so the read latency is 1 cycle.
REQ-014 SHALL hold rdata and rresp stable in R_DATA until rready, then return to R_IDLE.
REQ-015 SHALL, on a read of MTIME_LO, capture MTIME_HI into a shadow register; a subsequent MTIME_HI read SHALL return the shadow value.
REQ-016 SHALL implement the write FSM with states W_IDLE, W_ADDR (address held, awready=0), W_DATA (data held, wready=0) and W_RESP (bvalid=1).
REQ-017 SHALL assert awready and wready in W_IDLE; AW and W may arrive in either order or in the same cycle, and each is latched independently.
REQ-018 SHALL commit the write in the cycle both are held, then enter W_RESP; W_RESP SHALL exit to W_IDLE on bready, with awready=wready=0 throughout W_RESP.
REQ-019 SHALL apply byte writes per wstrb lane; wstrb=0 SHALL still return OKAY.
REQ-020 SHALL drive rresp/bresp to 2'b00 (OKAY), or 2'b10 (SLVERR) on a decode error; a decode-error write SHALL change no register, and a decode-error read SHALL return rdata=0.
REQ-021 SHALL let read and write FSMs run concurrently and independently.
REQ-022 SHALL increment mtime (64-bit) by 1 per tick, with wrap-around from 2^64-1 to 0.
REQ-023 SHALL give a same-cycle write to a mtime half priority over the increment; that half takes the written bytes, and a carry into the other half is suppressed that cycle.
REQ-024 SHALL register o_mtip as (mtime >= mtimecmp), unsigned 64-bit, updating 1 cycle after a change to mtime or mtimecmp.

Reset
REQ-025 SHALL, on i_rst, asynchronously set: mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, shadow=0, prescaler=0, o_mtip=0, read FSM=R_IDLE, write FSM=W_IDLE.
REQ-026 SHALL, on i_rst, drive rvalid=0, bvalid=0, rdata=0, rresp=0, bresp=0; arready, awready and wready then follow the idle states (1).
REQ-027 SHALL, on reset mid-transaction, discard the transaction with no register update and no response.

Configuration
REQ-028 SHALL, with CLINT_PRESCALER_EN defined, use a prescaler counter 0..DIV-1 and produce a tick when the counter wraps to 0.
REQ-029 SHALL, with CLINT_PRESCALER_EN defined, clear the prescaler on any write to MTIME_LO or MTIME_HI.
REQ-030 SHALL, without CLINT_PRESCALER_EN, tick every i_clk cycle; DIV is then unused and no prescaler logic is present.

Verification
REQ-031 SHALL verify: prescaler off, reset released, 10 cycles, read MTIME_LO -> rvalid 1 cycle after the AR handshake, rdata in 10..12, rresp=00.
REQ-032 SHALL verify: write MTIMECMP_HI=0, MTIMECMP_LO=0x20 with mtime<0x20 -> o_mtip=0 until mtime reaches 0x20, then 1 one cycle later.
REQ-033 SHALL verify: W presented 3 cycles before AW (wdata=0xDEADBEEF, wstrb=4'b0011, addr 0x8) -> single B response OKAY, MTIMECMP_LO=0xFFFFBEEF.
REQ-034 SHALL verify: write MTIME_LO=0xFFFFFFFF, MTIME_HI=0, then read LO then HI after wrap -> HI returns the shadow value captured at the LO read.
REQ-035 SHALL verify: read and write of addr 0x40 -> rresp=10, rdata=0, bresp=10, no register change; bready held low 5 cycles -> bvalid stays high and awready stays 0.
REQ-036 SHALL verify: with CLINT_PRESCALER_EN and DIV=4 -> mtime increments every 4 cycles; assert i_rst while rvalid=1 -> rvalid drops immediately and mtime=0.

Source files
------------

// File: rtl/axi_lite_clint.sv
// AXI-lite CLINT: 64-bit mtime/mtimecmp registers and a registered machine timer interrupt.
// Define CLINT_PRESCALER_EN to advance mtime once every DIV clocks instead of every clock.
module axi_lite_clint #(
   parameter int DIV = 16
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] awaddr,
   input  logic        awvalid,
   output logic        awready,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wvalid,
   output logic        wready,
   output logic [1:0]  bresp,
   output logic        bvalid,
   input  logic        bready,
   input  logic [31:0] araddr,
   input  logic        arvalid,
   output logic        arready,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rvalid,
   input  logic        rready,
   output logic        o_mtip
);
   typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;
   typedef enum logic [1:0] {W_IDLE = 2'd0, W_ADDR = 2'd1, W_DATA = 2'd2, W_RESP = 2'd3} w_state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   if (DIV < 2 || DIV > 65535) begin : g_div_check
      $error("axi_lite_clint: DIV must be within 2..65535");
   end

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
      logic [31:0] res;
      for (int i = 0; i < 4; i++) begin
         res[8*i +: 8] = strb[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
      end
      return res;
   endfunction

   r_state_t    r_state_r, r_state_nxt_s;
   w_state_t    w_state_r, w_state_nxt_s;
   logic        arready_r, rvalid_r, awready_r, wready_r, bvalid_r, mtip_r;
   logic [31:0] rdata_r, shadow_r, rd_data_s;
   logic [1:0]  rresp_r, bresp_r;
   logic        rd_fire_s, rd_err_s;
   logic [9:0]  awaddr_r, cm_addr_s;
   logic [31:0] wdata_r, cm_data_s;
   logic [3:0]  wstrb_r, cm_strb_s;
   logic        aw_take_s, w_take_s, commit_s, cm_err_s;
   logic        wr_lo_s, wr_hi_s, wr_clo_s, wr_chi_s, tick_s;
   logic [63:0] mtime_r, mtimecmp_r, mtime_nxt_s, mtimecmp_nxt_s, mtime_inc_s;
   logic        unused_s;

   // Address bits outside [11:2] carry no meaning for this block.
   assign unused_s = ^{awaddr[31:12], awaddr[1:0], araddr[31:12], araddr[1:0]};

   // Read FSM state register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state_r <= R_IDLE;
      else       r_state_r <= r_state_nxt_s;
   end

   // Read FSM next state and read-data selection.
   always_comb begin
      r_state_nxt_s = r_state_r;
      rd_fire_s     = 1'b0;
      rd_data_s     = 32'd0;
      rd_err_s      = (araddr[11:4] != 8'd0);
      case (r_state_r)
         R_IDLE: begin
            if (arvalid) begin
               rd_fire_s     = 1'b1;
               r_state_nxt_s = R_DATA;
            end else begin
               r_state_nxt_s = R_IDLE;
            end
         end
         R_DATA: begin
            if (rready) r_state_nxt_s = R_IDLE;
            else        r_state_nxt_s = R_DATA;
         end
         default: r_state_nxt_s = R_IDLE;
      endcase
      if (rd_err_s) begin
         rd_data_s = 32'd0;
      end else begin
         case (araddr[3:2])
            2'd0:    rd_data_s = mtime_r[31:0];
            2'd1:    rd_data_s = shadow_r;
            2'd2:    rd_data_s = mtimecmp_r[31:0];
            2'd3:    rd_data_s = mtimecmp_r[63:32];
            default: rd_data_s = 32'd0;
         endcase
      end
   end

   // Read channel outputs; a MTIME_LO read freezes the upper half for a tear-free HI read.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         arready_r <= 1'b1;
         rvalid_r  <= 1'b0;
         rdata_r   <= 32'd0;
         rresp_r   <= 2'b00;
         shadow_r  <= 32'd0;
      end else begin
         arready_r <= (r_state_nxt_s == R_IDLE);
         rvalid_r  <= (r_state_nxt_s == R_DATA);
         if (rd_fire_s) begin
            rdata_r <= rd_data_s;
            rresp_r <= rd_err_s ? RESP_SLVERR : RESP_OKAY;
            if (!rd_err_s && araddr[3:2] == 2'd0) shadow_r <= mtime_r[63:32];
         end
      end
   end

   // Write FSM state register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) w_state_r <= W_IDLE;
      else       w_state_r <= w_state_nxt_s;
   end

   // Write FSM next state; commit takes whichever half arrives live this cycle.
   always_comb begin
      w_state_nxt_s = w_state_r;
      aw_take_s     = 1'b0;
      w_take_s      = 1'b0;
      commit_s      = 1'b0;
      cm_addr_s     = awaddr_r;
      cm_data_s     = wdata_r;
      cm_strb_s     = wstrb_r;
      case (w_state_r)
         W_IDLE: begin
            if (awvalid && wvalid) begin
               commit_s      = 1'b1;
               cm_addr_s     = awaddr[11:2];
               cm_data_s     = wdata;
               cm_strb_s     = wstrb;
               w_state_nxt_s = W_RESP;
            end else if (awvalid) begin
               aw_take_s     = 1'b1;
               w_state_nxt_s = W_ADDR;
            end else if (wvalid) begin
               w_take_s      = 1'b1;
               w_state_nxt_s = W_DATA;
            end else begin
               w_state_nxt_s = W_IDLE;
            end
         end
         W_ADDR: begin
            if (wvalid) begin
               commit_s      = 1'b1;
               cm_data_s     = wdata;
               cm_strb_s     = wstrb;
               w_state_nxt_s = W_RESP;
            end else begin
               w_state_nxt_s = W_ADDR;
            end
         end
         W_DATA: begin
            if (awvalid) begin
               commit_s      = 1'b1;
               cm_addr_s     = awaddr[11:2];
               w_state_nxt_s = W_RESP;
            end else begin
               w_state_nxt_s = W_DATA;
            end
         end
         W_RESP: begin
            if (bready) w_state_nxt_s = W_IDLE;
            else        w_state_nxt_s = W_RESP;
         end
         default: w_state_nxt_s = W_IDLE;
      endcase
      cm_err_s = (cm_addr_s[9:2] != 8'd0);
   end

   // Write channel outputs and independently latched AW/W payloads.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         awready_r <= 1'b1;
         wready_r  <= 1'b1;
         bvalid_r  <= 1'b0;
         bresp_r   <= 2'b00;
         awaddr_r  <= 10'd0;
         wdata_r   <= 32'd0;
         wstrb_r   <= 4'd0;
      end else begin
         awready_r <= (w_state_nxt_s == W_IDLE) || (w_state_nxt_s == W_DATA);
         wready_r  <= (w_state_nxt_s == W_IDLE) || (w_state_nxt_s == W_ADDR);
         bvalid_r  <= (w_state_nxt_s == W_RESP);
         if (commit_s)  bresp_r  <= cm_err_s ? RESP_SLVERR : RESP_OKAY;
         if (aw_take_s) awaddr_r <= awaddr[11:2];
         if (w_take_s) begin
            wdata_r <= wdata;
            wstrb_r <= wstrb;
         end
      end
   end

   assign wr_lo_s  = commit_s && !cm_err_s && (cm_addr_s[1:0] == 2'd0);
   assign wr_hi_s  = commit_s && !cm_err_s && (cm_addr_s[1:0] == 2'd1);
   assign wr_clo_s = commit_s && !cm_err_s && (cm_addr_s[1:0] == 2'd2);
   assign wr_chi_s = commit_s && !cm_err_s && (cm_addr_s[1:0] == 2'd3);

`ifdef CLINT_PRESCALER_EN
   logic [15:0] presc_r;
   assign tick_s = (presc_r == 16'(DIV - 1));

   // Prescaler restarts on any mtime write so the new value lasts a full period.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)                   presc_r <= 16'd0;
      else if (wr_lo_s || wr_hi_s) presc_r <= 16'd0;
      else if (tick_s)             presc_r <= 16'd0;
      else                         presc_r <= presc_r + 16'd1;
   end
`else
   assign tick_s = 1'b1;
`endif

   // Next mtime/mtimecmp: a written mtime half wins and blocks the carry across halves.
   always_comb begin
      mtime_inc_s    = mtime_r + 64'd1;
      mtime_nxt_s    = mtime_r;
      mtimecmp_nxt_s = mtimecmp_r;
      if (wr_lo_s) begin
         mtime_nxt_s = {mtime_r[63:32], merge_bytes(mtime_r[31:0], cm_data_s, cm_strb_s)};
      end else if (wr_hi_s) begin
         mtime_nxt_s = {merge_bytes(mtime_r[63:32], cm_data_s, cm_strb_s),
                        (tick_s ? mtime_inc_s[31:0] : mtime_r[31:0])};
      end else if (tick_s) begin
         mtime_nxt_s = mtime_inc_s;
      end else begin
         mtime_nxt_s = mtime_r;
      end
      if (wr_clo_s) begin
         mtimecmp_nxt_s[31:0] = merge_bytes(mtimecmp_r[31:0], cm_data_s, cm_strb_s);
      end else if (wr_chi_s) begin
         mtimecmp_nxt_s[63:32] = merge_bytes(mtimecmp_r[63:32], cm_data_s, cm_strb_s);
      end else begin
         mtimecmp_nxt_s = mtimecmp_r;
      end
   end

   // Timer registers and the interrupt flag.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         mtime_r    <= 64'd0;
         mtimecmp_r <= 64'hFFFF_FFFF_FFFF_FFFF;
         mtip_r     <= 1'b0;
      end else begin
         mtime_r    <= mtime_nxt_s;
         mtimecmp_r <= mtimecmp_nxt_s;
         mtip_r     <= (mtime_r >= mtimecmp_r);
      end
   end

   assign arready = arready_r;
   assign rvalid  = rvalid_r;
   assign rdata   = rdata_r;
   assign rresp   = rresp_r;
   assign awready = awready_r;
   assign wready  = wready_r;
   assign bvalid  = bvalid_r;
   assign bresp   = bresp_r;
   assign o_mtip  = mtip_r;
endmodule

// File: tb/tb_axi_lite_clint.sv
// Self-checking bench for axi_lite_clint: directed scenarios plus randomized AXI-lite traffic
// compared against a timeline model of mtime (value = base + elapsed_cycles / tick_period).
module tb_axi_lite_clint;
`ifdef CLINT_PRESCALER_EN
   localparam int TICK = 4;
`else
   localparam int TICK = 1;
`endif

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic [31:0] awaddr = 32'd0, wdata = 32'd0, araddr = 32'd0;
   logic [3:0]  wstrb = 4'd0;
   logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
   logic        awready, wready, bvalid, arready, rvalid, o_mtip;
   logic [1:0]  bresp, rresp;
   logic [31:0] rdata;

   axi_lite_clint #(.DIV(4)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .o_mtip(o_mtip)
   );

   always #5 i_clk = ~i_clk;

   int          n_checks = 0;
   int          n_fails  = 0;
   longint      cyc      = 0;
   logic [63:0] base_val = 64'd0;
   longint      base_cyc = 0;
   logic [63:0] cmp_m    = 64'hFFFF_FFFF_FFFF_FFFF;
   logic [31:0] shadow_m = 32'd0;

   function automatic logic [63:0] mtime_at(input longint n);
      return base_val + 64'((n - base_cyc) / TICK);
   endfunction

   function automatic logic [31:0] lanes(input logic [31:0] old_v, input logic [31:0] new_v,
                                         input logic [3:0] strb);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
      return r;
   endfunction

   task automatic tick();
      @(posedge i_clk);
      cyc++;
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_mtip(input string tag);
      check(tag, {63'd0, o_mtip}, {63'd0, (mtime_at(cyc - 1) >= cmp_m)});
   endtask

   task automatic model_reset();
      base_val = 64'd0;
      base_cyc = cyc;
      cmp_m    = 64'hFFFF_FFFF_FFFF_FFFF;
      shadow_m = 32'd0;
   endtask

   // Apply a committed write at edge c to the reference model.
   task automatic model_write(input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input longint c);
      logic [63:0] prev, now_v;
      if (addr[11:4] != 8'd0) return;
      prev  = mtime_at(c - 1);
      now_v = mtime_at(c);
      case (addr[3:2])
         2'd0: begin
            base_val = {prev[63:32], lanes(prev[31:0], data, strb)};
            base_cyc = c;
         end
         2'd1: begin
            base_val = {lanes(prev[63:32], data, strb), prev[31:0] + now_v[31:0] - prev[31:0]};
            base_cyc = c;
         end
         2'd2: cmp_m[31:0]  = lanes(cmp_m[31:0], data, strb);
         default: cmp_m[63:32] = lanes(cmp_m[63:32], data, strb);
      endcase
   endtask

   // lead > 0: W leads AW by lead cycles; lead < 0: AW leads W; 0: same cycle.
   task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int lead, input int bwait, input string tag);
      logic [1:0] exp_resp;
      exp_resp = (addr[11:4] != 8'd0) ? 2'b10 : 2'b00;
      if (lead > 0) begin
         wdata = data; wstrb = strb; wvalid = 1'b1;
         tick();
         wvalid = 1'b0; wdata = $urandom; wstrb = 4'($urandom);
         check({tag, "_wready_held"}, {63'd0, wready}, 64'd0);
         repeat (lead - 1) tick();
         awaddr = addr; awvalid = 1'b1;
         tick();
         awvalid = 1'b0;
      end else if (lead < 0) begin
         awaddr = addr; awvalid = 1'b1;
         tick();
         awvalid = 1'b0; awaddr = $urandom;
         check({tag, "_awready_held"}, {63'd0, awready}, 64'd0);
         repeat (-lead - 1) tick();
         wdata = data; wstrb = strb; wvalid = 1'b1;
         tick();
         wvalid = 1'b0;
      end else begin
         awaddr = addr; awvalid = 1'b1; wdata = data; wstrb = strb; wvalid = 1'b1;
         tick();
         awvalid = 1'b0; wvalid = 1'b0;
      end
      model_write(addr, data, strb, cyc);
      check({tag, "_bvalid"}, {63'd0, bvalid}, 64'd1);
      check({tag, "_bresp"}, {62'd0, bresp}, {62'd0, exp_resp});
      check({tag, "_ready_in_resp"}, {62'd0, awready, wready}, 64'd0);
      for (int i = 0; i < bwait; i++) begin
         tick();
         check({tag, "_bvalid_hold"}, {63'd0, bvalid}, 64'd1);
         check({tag, "_awready_hold"}, {63'd0, awready}, 64'd0);
      end
      bready = 1'b1;
      tick();
      bready = 1'b0;
      check({tag, "_bvalid_done"}, {63'd0, bvalid}, 64'd0);
      check({tag, "_awready_back"}, {63'd0, awready}, 64'd1);
   endtask

   task automatic do_read(input logic [31:0] addr, input int rwait, input string tag,
                          output logic [31:0] got);
      logic [31:0] exp_d;
      logic [63:0] mt;
      logic [1:0]  exp_resp;
      araddr = addr; arvalid = 1'b1;
      tick();
      arvalid = 1'b0; araddr = $urandom;
      mt = mtime_at(cyc - 1);
      exp_resp = 2'b00;
      if (addr[11:4] != 8'd0) begin
         exp_d = 32'd0;
         exp_resp = 2'b10;
      end else begin
         case (addr[3:2])
            2'd0: begin exp_d = mt[31:0]; shadow_m = mt[63:32]; end
            2'd1: exp_d = shadow_m;
            2'd2: exp_d = cmp_m[31:0];
            default: exp_d = cmp_m[63:32];
         endcase
      end
      check({tag, "_rvalid"}, {63'd0, rvalid}, 64'd1);
      check({tag, "_rdata"}, {32'd0, rdata}, {32'd0, exp_d});
      check({tag, "_rresp"}, {62'd0, rresp}, {62'd0, exp_resp});
      got = rdata;
      for (int i = 0; i < rwait; i++) begin
         tick();
         check({tag, "_rdata_hold"}, {32'd0, rdata}, {32'd0, exp_d});
         check({tag, "_arready_hold"}, {62'd0, arready, rvalid}, 64'd1);
      end
      rready = 1'b1;
      tick();
      rready = 1'b0;
      check({tag, "_r_done"}, {62'd0, arready, rvalid}, 64'd2);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_valids"}, {61'd0, rvalid, bvalid, o_mtip}, 64'd0);
      check({tag, "_readies"}, {61'd0, arready, awready, wready}, 64'd7);
      check({tag, "_rdata"}, {32'd0, rdata}, 64'd0);
      check({tag, "_resps"}, {60'd0, rresp, bresp}, 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] got, addr, data;
      bit          seen_low, seen_rise;
      int          sel;

      repeat (3) tick();
      check_idle_outputs("reset");
      i_rst = 1'b0;
      model_reset();

      repeat (10) tick();
      do_read(32'h0, 0, "mtime_lo_first", got);
`ifndef CLINT_PRESCALER_EN
      check("mtime_lo_range", {63'd0, (got >= 32'd10 && got <= 32'd12)}, 64'd1);
`endif

      do_write(32'h8, 32'hDEAD_BEEF, 4'b0011, 3, 0, "w_before_aw");
      do_read(32'h8, 1, "cmp_lo_partial", got);
      check("cmp_lo_bytes", {32'd0, got}, 64'hFFFF_BEEF);

      do_write(32'h4, 32'h0, 4'hF, 0, 0, "mt_hi_zero");
      do_write(32'h0, 32'hFFFF_FFFF, 4'hF, -1, 1, "mt_lo_ones");
      repeat (6) tick();
      do_read(32'h0, 0, "wrap_lo", got);
      do_write(32'h4, 32'h0000_00A5, 4'hF, 1, 0, "mt_hi_a5");
      do_read(32'h4, 2, "wrap_hi_shadow", got);
      check("shadow_after_wrap", {32'd0, got}, 64'd1);

      do_write(32'h4, 32'h0, 4'hF, 0, 0, "mt_hi_clr");
      do_write(32'h0, 32'h0, 4'hF, 0, 0, "mt_lo_clr");
      do_write(32'hC, 32'h0, 4'hF, 1, 0, "cmp_hi_clr");
      do_write(32'h8, 32'h20, 4'hF, -2, 0, "cmp_lo_20");
      seen_low = 1'b0; seen_rise = 1'b0;
      for (int i = 0; i < 400 && mtime_at(cyc - 1) < 64'h24; i++) begin
         check_mtip("mtip_track");
         if (o_mtip === 1'b0) seen_low = 1'b1;
         else if (seen_low) seen_rise = 1'b1;
         tick();
      end
      check("mtip_rose", {63'd0, seen_rise}, 64'd1);

      do_write(32'h40, 32'h1234_5678, 4'hF, 0, 5, "err_write");
      do_read(32'h40, 0, "err_read", got);
      do_read(32'h8, 0, "cmp_lo_kept", got);
      do_read(32'hC, 0, "cmp_hi_kept", got);
      do_read(32'hFFFF_F00B, 0, "alias_cmp_lo", got);

      for (int k = 0; k < 40; k++) begin
         sel  = $urandom_range(0, 3);
         addr = $urandom;
         addr[11:4] = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
         addr[3:2]  = 2'(sel);
         data = $urandom;
         if ($urandom_range(0, 1) == 1)
            do_write(addr, data, 4'($urandom), $urandom_range(0, 4) - 2, $urandom_range(0, 2), "rnd_w");
         else
            do_read(addr, $urandom_range(0, 2), "rnd_r", got);
         check_mtip("rnd_mtip");
      end

      wdata = 32'h0; wstrb = 4'hF; wvalid = 1'b1;
      tick();
      wvalid = 1'b0;
      araddr = 32'h8; arvalid = 1'b1;
      tick();
      arvalid = 1'b0;
      check("pre_reset_rvalid", {63'd0, rvalid}, 64'd1);
      i_rst = 1'b1;
      #1;
      check_idle_outputs("mid_reset");
      repeat (2) tick();
      i_rst = 1'b0;
      model_reset();
      repeat (7) tick();
      do_read(32'h0, 0, "post_reset_lo", got);
      do_read(32'h4, 0, "post_reset_hi", got);
      do_read(32'h8, 0, "post_reset_cmp_lo", got);
      repeat (5) tick();
      do_read(32'h0, 1, "post_reset_lo2", got);
      check_mtip("post_reset_mtip");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
